avmm_master: RTL and testbench
==============================

Name: avmm_master

Overview:
- Avalon-MM initiator: converts a simple valid/ready command stream into Avalon-MM single-word reads and writes.
- Honours waitrequest and pipelined readdatavalid, and buffers read data in a response FIFO.
- It is the initiator counterpart to the board's zero-wait memory-mapped register-file slaves.
- Used on-chip in place of the JTAG bridge master, to drive those slaves from logic or a soft core.

Parameters:
- ADDR_WIDTH, 32, Avalon byte address width.
- DATA_WIDTH, 32, data width; a multiple of 8. BE_WIDTH = DATA_WIDTH/8 is derived.
- DEPTH, 4, response FIFO depth and maximum reads in flight; a power of 2, at least 2.

Ports:
- clk_clk  in  1  clock; all logic is on the rising edge.
- reset_reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_address  in  ADDR_WIDTH  byte address.
- cmd_writedata  in  DATA_WIDTH  write data.
- cmd_byteenable  in  BE_WIDTH  byte lanes.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer pops when rsp_valid & rsp_ready.
- rsp_readdata  out  DATA_WIDTH  read data, returned in issue order.
- avm_address  out  ADDR_WIDTH  Avalon address.
- avm_read  out  1  Avalon read.
- avm_write  out  1  Avalon write.
- avm_writedata  out  DATA_WIDTH  Avalon write data.
- avm_byteenable  out  BE_WIDTH  Avalon byte enables.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  DATA_WIDTH  slave read data.
- avm_readdatavalid  in  1  slave read data valid.
- busy  out  1  transfer issuing or reads outstanding.
- err  out  1  sticky protocol error flag.

Behaviour:
Reset:
- Asynchronous; all state clears.
- avm_read = avm_write = 0, avm_address, avm_writedata and avm_byteenable = 0.
- FIFO empty, rsp_valid = 0, credit count = 0, err = 0, busy = 0.
- Reset mid-transfer abandons the transfer; there is no recovery of in-flight reads.

State machine (IDLE, ISSUE); all avm_* outputs are registered:
- IDLE: cmd_ready = (cnt < DEPTH). On accept, latch the command and go to ISSUE. avm_read or avm_write rises the cycle after accept (1-cycle latency).
- ISSUE: avm_* is held stable while avm_waitrequest = 1.
- The transfer completes in a cycle with avm_waitrequest = 0. In that same cycle cmd_ready = (cnt_next_free). If a command is accepted, load it and stay in ISSUE (back-to-back, one transfer per cycle at zero wait). Otherwise drop avm_read/avm_write and return to IDLE.
- cmd_ready never depends on cmd_write or any other cmd_* field.

Credits:
- cnt = reads accepted but not yet popped from rsp. Range 0..DEPTH.
- Increments on a read command accept; decrements on a rsp pop; simultaneous accept and pop leave cnt unchanged.
- Credits gate every command, including writes, so that cmd_ready is type-independent.
- Writes carry no response and do not change cnt.

Responses:
- avm_readdatavalid pushes avm_readdata into the FIFO.
- The FIFO is show-ahead: data appears on rsp_readdata and rsp_valid the cycle after readdatavalid.
- Push and pop in the same cycle are both allowed when the FIFO is non-empty.
- readdatavalid while the FIFO is full, or while no read is outstanding, sets err (sticky until reset). A push into a full FIFO is dropped.

Status:
- busy = (state == ISSUE) | (cnt != 0).
- Address and data pass through unmodified; no alignment check is made.

Decomposition:
- Shared package: the state encoding (IDLE/ISSUE) and a BE_WIDTH derivation helper.
- One sub-module, avmm_rsp_fifo: synchronous show-ahead FIFO with parameters DEPTH and DATA_WIDTH, ports push/pop/full/empty, pointers of log2(DEPTH)+1 bits, and the same asynchronous active-low reset.
- Top level: FSM, credit counter and error logic.

Test Plan:
- Single write: cmd write addr 0x4, data 0xDEADBEEF, be 0xF, waitrequest = 0. Expect avm_write high for exactly 1 cycle, the cycle after accept, with the address and data as given; rsp_valid stays 0; busy falls the cycle after.
- Read with wait states: read addr 0x8, waitrequest high for 3 cycles. Expect avm_read and avm_address stable for 4 cycles. Then readdatavalid with 0x12345678 two cycles later; rsp_valid rises the next cycle with 0x12345678.
- Pipelined reads to credit limit, DEPTH = 4: 6 back-to-back reads, rsp_ready = 0, slave returns after 5 cycles. Expect 4 accepts in consecutive cycles, then cmd_ready = 0. Popping one response re-enables exactly one accept. Data is returned in order.
- Mixed back-to-back: write, read, write at zero wait. Expect avm_write, avm_read, avm_write in 3 consecutive cycles with no idle bubble; cnt peaks at 1.
- Error: readdatavalid with no read outstanding. Expect err = 1 the next cycle, held until reset; FIFO contents unchanged.
- Reset mid-read: assert reset_reset_n = 0 while avm_read is high. Expect avm_read = 0 immediately (asynchronous), cnt = 0, rsp_valid = 0, err = 0.

Source files
------------

// File: rtl/avmm_master_pkg.sv
// Shared types for the Avalon-MM initiator: issue FSM encoding and the
// byte-enable width derivation used by the interface and the top level.
package avmm_master_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/avmm_master_if.sv
// Command, response and Avalon-MM bus signals of the initiator; the master
// modport is the initiator's view, the slave modport is everything around it.
interface avmm_master_if
  import avmm_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = be_width(DATA_WIDTH);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_address;
  logic [DATA_WIDTH-1:0] cmd_writedata;
  logic [BE_WIDTH-1:0]   cmd_byteenable;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_readdata;

  logic [ADDR_WIDTH-1:0] avm_address;
  logic                  avm_read;
  logic                  avm_write;
  logic [DATA_WIDTH-1:0] avm_writedata;
  logic [BE_WIDTH-1:0]   avm_byteenable;
  logic                  avm_waitrequest;
  logic [DATA_WIDTH-1:0] avm_readdata;
  logic                  avm_readdatavalid;

  modport master (
    input  cmd_valid, cmd_write, cmd_address, cmd_writedata, cmd_byteenable,
    input  rsp_ready,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid,
    output cmd_ready, rsp_valid, rsp_readdata,
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_address, cmd_writedata, cmd_byteenable,
    output rsp_ready,
    output avm_waitrequest, avm_readdata, avm_readdatavalid,
    input  cmd_ready, rsp_valid, rsp_readdata,
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
  );

endinterface

// File: rtl/avmm_rsp_fifo.sv
// Show-ahead response FIFO: the head entry is visible on rdata_o whenever
// empty_o is low. Pointers carry one wrap bit to tell full from empty.
module avmm_rsp_fifo #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  full_o,
  output logic                  empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]           wptr_q;
  logic [AW:0]           rptr_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i && !full_o) begin
        mem_q[wptr_q[AW-1:0]] <= wdata_i;
        wptr_q                <= wptr_q + 1'b1;
      end
      if (pop_i && !empty_o) rptr_q <= rptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/avmm_master.sv
// Avalon-MM initiator: turns a valid/ready command stream into single-word
// Avalon reads/writes, with credit-limited pipelined reads into a response FIFO.
module avmm_master
  import avmm_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic          clk_clk,
  input  logic          reset_reset_n,
  avmm_master_if.master bus,
  output logic          busy,
  output logic          err
);
  localparam int BE_WIDTH = be_width(DATA_WIDTH);
  localparam int CW       = $clog2(DEPTH) + 1;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] avm_address_q;
  logic [DATA_WIDTH-1:0] avm_writedata_q;
  logic [BE_WIDTH-1:0]   avm_byteenable_q;
  logic                  avm_read_q;
  logic                  avm_write_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         inflight_q, inflight_d;
  logic                  err_q, err_d;

  logic accept, rd_accept, xfer_done, cnt_free;
  logic fifo_push, fifo_pop, fifo_full, fifo_empty, rdv_bad;

  // Credits count reads not yet popped, so every command (writes included)
  // is gated by them and cmd_ready never depends on the command type.
  assign cnt_free      = (cnt_q < CW'(DEPTH));
  assign xfer_done     = (state_q == ISSUE) && !bus.avm_waitrequest;
  assign bus.cmd_ready = cnt_free && ((state_q == IDLE) || !bus.avm_waitrequest);
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign rd_accept     = accept && !bus.cmd_write;

  assign fifo_pop      = bus.rsp_valid && bus.rsp_ready;
  assign rdv_bad       = bus.avm_readdatavalid && (fifo_full || (inflight_q == '0));
  assign fifo_push     = bus.avm_readdatavalid && !rdv_bad;

  assign bus.rsp_valid      = !fifo_empty;
  assign bus.avm_address    = avm_address_q;
  assign bus.avm_writedata  = avm_writedata_q;
  assign bus.avm_byteenable = avm_byteenable_q;
  assign bus.avm_read       = avm_read_q;
  assign bus.avm_write      = avm_write_q;

  assign busy = (state_q == ISSUE) || (cnt_q != '0);
  assign err  = err_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q          <= IDLE;
      avm_address_q    <= '0;
      avm_writedata_q  <= '0;
      avm_byteenable_q <= '0;
      avm_read_q       <= 1'b0;
      avm_write_q      <= 1'b0;
    end else if (accept) begin
      // Accept is only possible in IDLE or on the completing ISSUE cycle.
      state_q          <= ISSUE;
      avm_address_q    <= bus.cmd_address;
      avm_writedata_q  <= bus.cmd_writedata;
      avm_byteenable_q <= bus.cmd_byteenable;
      avm_read_q       <= !bus.cmd_write;
      avm_write_q      <= bus.cmd_write;
    end else if (xfer_done) begin
      state_q     <= IDLE;
      avm_read_q  <= 1'b0;
      avm_write_q <= 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (rd_accept && !fifo_pop)      cnt_d = cnt_q + 1'b1;
    else if (!rd_accept && fifo_pop) cnt_d = cnt_q - 1'b1;
    inflight_d = inflight_q;
    if (rd_accept && !fifo_push)      inflight_d = inflight_q + 1'b1;
    else if (!rd_accept && fifo_push) inflight_d = inflight_q - 1'b1;
    err_d = err_q || rdv_bad;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cnt_q      <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  avmm_rsp_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk_i   (clk_clk),
    .rst_ni  (reset_reset_n),
    .push_i  (fifo_push),
    .wdata_i (bus.avm_readdata),
    .pop_i   (fifo_pop),
    .rdata_o (bus.rsp_readdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_avmm_master.sv
// Bench for avmm_master: directed scenarios plus a randomized phase, checked
// every cycle against a transaction-level model (queues + word memory).
module tb_avmm_master;
  import avmm_master_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int BW    = be_width(DW);

  logic clk_clk = 1'b0;
  logic reset_reset_n = 1'b0;
  logic busy, err;

  always #5 clk_clk = ~clk_clk;

  avmm_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  avmm_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .bus           (bus),
    .busy          (busy),
    .err           (err)
  );

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
  } xfer_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } ret_t;

  // Model: accepted-but-not-completed bus transfers, read data owed to the
  // consumer in order, and how many of those already sit in the FIFO.
  xfer_t         exp_bus[$];
  logic [DW-1:0] exp_rsp[$];
  int            n_fifo;
  bit            err_m;
  logic [DW-1:0] mm [16];

  // Slave: its own memory and a queue of pending read returns.
  logic [DW-1:0] slv_mem [16];
  ret_t          slv_q[$];
  int            cyc, last_due, stall_left, lat_min, lat_max;
  bit            rand_wait, slv_drove;

  int n_acc, n_xfer, n_wr_hi, n_rd_hi, x0;
  int checks, failures;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    bit pend, erd, ewr;
    pend = (exp_bus.size() > 0);
    erd  = 1'b0;
    ewr  = 1'b0;
    if (pend) begin
      erd = !exp_bus[0].wr;
      ewr = exp_bus[0].wr;
    end
    chk("cmd_ready", bus.cmd_ready,
        64'((!pend || !bus.avm_waitrequest) && (exp_rsp.size() < DEPTH)));
    chk("avm_read", bus.avm_read, 64'(erd));
    chk("avm_write", bus.avm_write, 64'(ewr));
    if (pend) begin
      chk("avm_address", bus.avm_address, exp_bus[0].addr);
      chk("avm_byteenable", bus.avm_byteenable, exp_bus[0].be);
      if (ewr) chk("avm_writedata", bus.avm_writedata, exp_bus[0].data);
    end
    chk("rsp_valid", bus.rsp_valid, 64'(n_fifo > 0));
    if (n_fifo > 0) chk("rsp_readdata", bus.rsp_readdata, exp_rsp[0]);
    chk("busy", busy, 64'(pend || (exp_rsp.size() != 0)));
    chk("err", err, 64'(err_m));
  endtask

  // One clock: check, account for this edge's events, advance, drive slave.
  task automatic cycle();
    bit    acc, xf, pp, rdv;
    xfer_t t;
    ret_t  r;
    int    idx;
    #1;
    check_outputs();
    acc = bus.cmd_valid && bus.cmd_ready;
    xf  = (bus.avm_read || bus.avm_write) && !bus.avm_waitrequest;
    pp  = bus.rsp_valid && bus.rsp_ready;
    rdv = bus.avm_readdatavalid;
    if (bus.avm_write) n_wr_hi++;
    if (bus.avm_read)  n_rd_hi++;
    if (xf) begin
      n_xfer++;
      idx = int'(bus.avm_address[5:2]);
      if (bus.avm_write) begin
        slv_mem[idx] = merge(slv_mem[idx], bus.avm_writedata, bus.avm_byteenable);
      end else begin
        r.due = cyc + int'($urandom_range(lat_max, lat_min));
        if (r.due <= last_due) r.due = last_due + 1;
        last_due = r.due;
        r.data   = slv_mem[idx];
        slv_q.push_back(r);
      end
      if (exp_bus.size() > 0) void'(exp_bus.pop_front());
    end
    if (slv_drove) void'(slv_q.pop_front());
    if (rdv) begin
      if (n_fifo == DEPTH || (exp_rsp.size() - n_fifo) == 0) err_m = 1'b1;
      else n_fifo++;
    end
    if (pp && exp_rsp.size() > 0) begin
      void'(exp_rsp.pop_front());
      n_fifo--;
    end
    if (acc) begin
      n_acc++;
      t.wr   = bus.cmd_write;
      t.addr = bus.cmd_address;
      t.data = bus.cmd_writedata;
      t.be   = bus.cmd_byteenable;
      exp_bus.push_back(t);
      idx = int'(t.addr[5:2]);
      if (t.wr) mm[idx] = merge(mm[idx], t.data, t.be);
      else      exp_rsp.push_back(mm[idx]);
    end
    @(posedge clk_clk);
    cyc++;
    #1;
    if (rand_wait)           bus.avm_waitrequest = ($urandom_range(2, 0) == 0);
    else if (stall_left > 0) begin bus.avm_waitrequest = 1'b1; stall_left--; end
    else                     bus.avm_waitrequest = 1'b0;
    slv_drove = 1'b0;
    bus.avm_readdatavalid = 1'b0;
    if (slv_q.size() > 0 && slv_q[0].due <= cyc) begin
      bus.avm_readdatavalid = 1'b1;
      bus.avm_readdata      = slv_q[0].data;
      slv_drove             = 1'b1;
    end
  endtask

  task automatic set_cmd(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [BW-1:0] be);
    bus.cmd_valid      = 1'b1;
    bus.cmd_write      = wr;
    bus.cmd_address    = a;
    bus.cmd_writedata  = d;
    bus.cmd_byteenable = be;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; cyc = 0; last_due = 0; stall_left = 0;
    lat_min = 1; lat_max = 1; rand_wait = 1'b0; slv_drove = 1'b0;
    n_fifo = 0; err_m = 1'b0; n_acc = 0; n_xfer = 0; n_wr_hi = 0; n_rd_hi = 0;
    for (int i = 0; i < 16; i++) begin
      slv_mem[i] = 32'hC0DE0000 + i;
      mm[i]      = 32'hC0DE0000 + i;
    end
    slv_mem[2] = 32'h12345678;
    mm[2]      = 32'h12345678;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_address = '0;
    bus.cmd_writedata = '0; bus.cmd_byteenable = '0; bus.rsp_ready = 1'b0;
    bus.avm_waitrequest = 1'b0; bus.avm_readdata = '0; bus.avm_readdatavalid = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_clk);
    #1;
    chk("rst_avm_read", bus.avm_read, 0);
    chk("rst_avm_write", bus.avm_write, 0);
    chk("rst_avm_address", bus.avm_address, 0);
    chk("rst_avm_writedata", bus.avm_writedata, 0);
    chk("rst_avm_byteenable", bus.avm_byteenable, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    reset_reset_n = 1'b1;
    @(posedge clk_clk);
    #1;

    // Single write at zero wait
    n_wr_hi = 0;
    set_cmd(1'b1, 32'h4, 32'hDEADBEEF, 4'hF);
    cycle();
    bus.cmd_valid = 1'b0;
    repeat (3) cycle();
    chk("single_write_pulse", n_wr_hi, 1);

    // Read with three wait states, data two cycles after completion
    n_rd_hi = 0; lat_min = 2; lat_max = 2;
    set_cmd(1'b0, 32'h8, 32'h0, 4'hF);
    stall_left = 3;
    cycle();
    bus.cmd_valid = 1'b0;
    repeat (8) cycle();
    chk("wait_read_hold", n_rd_hi, 4);
    chk("wait_read_valid", bus.rsp_valid, 1);
    chk("wait_read_data", bus.rsp_readdata, 32'h12345678);
    bus.rsp_ready = 1'b1;
    cycle();
    bus.rsp_ready = 1'b0;
    cycle();

    // Pipelined reads up to the credit limit
    lat_min = 5; lat_max = 5; n_acc = 0;
    for (int k = 0; k < 12; k++) begin
      set_cmd(1'b0, AW'(n_acc * 4), 32'h0, 4'hF);
      cycle();
    end
    chk("credit_accepts", n_acc, 4);
    #1;
    chk("credit_cmd_ready", bus.cmd_ready, 0);
    bus.rsp_ready = 1'b1;
    cycle();
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_cmd(1'b0, AW'(n_acc * 4), 32'h0, 4'hF);
      cycle();
    end
    chk("credit_one_more", n_acc, 5);
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (n_acc == 6) bus.cmd_valid = 1'b0;
      else set_cmd(1'b0, AW'(n_acc * 4), 32'h0, 4'hF);
      cycle();
    end
    chk("credit_total", n_acc, 6);
    chk("credit_drained", busy, 0);

    // Mixed write/read/write back-to-back
    lat_min = 1; lat_max = 1;
    set_cmd(1'b1, 32'h10, 32'hA1B2C3D4, 4'hF);
    cycle();
    x0 = n_xfer;
    set_cmd(1'b0, 32'h10, 32'h0, 4'hF);
    cycle();
    set_cmd(1'b1, 32'h14, 32'h55AA55AA, 4'h5);
    cycle();
    bus.cmd_valid = 1'b0;
    cycle();
    chk("b2b_xfers", n_xfer - x0, 3);
    repeat (4) cycle();

    // Spurious readdatavalid with one genuine response parked in the FIFO
    bus.rsp_ready = 1'b0;
    set_cmd(1'b0, 32'h8, 32'h0, 4'hF);
    cycle();
    bus.cmd_valid = 1'b0;
    repeat (4) cycle();
    bus.avm_readdata      = 32'hBAD0BAD0;
    bus.avm_readdatavalid = 1'b1;
    cycle();
    repeat (3) cycle();
    chk("err_sticky", err, 1);
    chk("err_fifo_head", bus.rsp_readdata, 32'h12345678);
    bus.rsp_ready = 1'b1;
    cycle();
    bus.rsp_ready = 1'b0;
    repeat (2) cycle();

    // Reset asserted while a read is stalled on the bus
    set_cmd(1'b0, 32'hC, 32'h0, 4'hF);
    stall_left = 10;
    cycle();
    bus.cmd_valid = 1'b0;
    repeat (2) cycle();
    chk("pre_reset_avm_read", bus.avm_read, 1);
    reset_reset_n = 1'b0;
    #1;
    chk("midrst_avm_read", bus.avm_read, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    chk("midrst_err", err, 0);
    exp_bus.delete(); exp_rsp.delete(); slv_q.delete();
    n_fifo = 0; err_m = 1'b0; stall_left = 0; slv_drove = 1'b0;
    bus.avm_waitrequest = 1'b0; bus.avm_readdatavalid = 1'b0;
    @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b1;
    @(posedge clk_clk);
    #1;

    // Randomized traffic with random waits, latencies and consumer stalls
    rand_wait = 1'b1; lat_min = 1; lat_max = 4;
    for (int k = 0; k < 600; k++) begin
      bus.cmd_valid      = 1'($urandom_range(1, 0));
      bus.cmd_write      = 1'($urandom_range(1, 0));
      bus.cmd_address    = $urandom();
      bus.cmd_writedata  = $urandom();
      bus.cmd_byteenable = BW'($urandom_range(15, 0));
      if (k < 300) bus.rsp_ready = ($urandom_range(3, 0) == 0);
      else         bus.rsp_ready = ($urandom_range(3, 0) != 0);
      cycle();
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    rand_wait     = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (!busy && slv_q.size() == 0) break;
      cycle();
    end
    cycle();
    chk("random_drained", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
